// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the 7-segment bus, used by both the display driver
// and the scan decoder so the two ends agree on segment order and glyphs.
//
// Bit order: segment vectors are declared [0:6], so index 0 is segment a and
// index 6 is segment g. Literals therefore read left to right as a..g.
package seg7_pkg;

  localparam logic [0:6] SEG_0     = 7'b1111110;
  localparam logic [0:6] SEG_1     = 7'b0110000;
  localparam logic [0:6] SEG_2     = 7'b1101101;
  localparam logic [0:6] SEG_3     = 7'b1111001;
  localparam logic [0:6] SEG_4     = 7'b0110011;
  localparam logic [0:6] SEG_5     = 7'b1011011;
  localparam logic [0:6] SEG_6     = 7'b1011111;
  localparam logic [0:6] SEG_7     = 7'b1110000;
  localparam logic [0:6] SEG_8     = 7'b1111111;
  localparam logic [0:6] SEG_9     = 7'b1111011;
  localparam logic [0:6] SEG_BLANK = 7'b0000000;

  // A dark digit is a legitimate display state and is carried through the
  // datapath with this code rather than being flagged as an error.
  localparam logic [3:0] BLANK_CODE = 4'hF;

endpackage

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd
// Combinational inverse of the BCD-to-7-segment driver.
//
// Ports:
//   seg   in  [0:6]  segment pattern, index 0 = a ... 6 = g
//   valid out 1      pattern is a digit 0-9 or blank
//   value out [3:0]  decoded digit, BLANK_CODE for blank, 0 when not valid
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [0:6] seg,
  output logic       valid,
  output logic [3:0] value
);

  always_comb begin
    valid = 1'b1;
    value = 4'd0;
    case (seg)
      SEG_0:     value = 4'd0;
      SEG_1:     value = 4'd1;
      SEG_2:     value = 4'd2;
      SEG_3:     value = 4'd3;
      SEG_4:     value = 4'd4;
      SEG_5:     value = 4'd5;
      SEG_6:     value = 4'd6;
      SEG_7:     value = 4'd7;
      SEG_8:     value = 4'd8;
      SEG_9:     value = 4'd9;
      SEG_BLANK: value = BLANK_CODE;
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Watches a multiplexed 7-segment bus, debounces each digit dwell, decodes
// the stable pattern back to BCD and assembles complete multi-digit frames.
//
// Ports:
//   clk          in  1               rising-edge clock
//   clr          in  1               synchronous active-low reset
//   seg_in       in  [0:6]           segment lines, index 0 = a, 1 = lit
//   dig_sel      in  NUM_DIGITS      one-hot digit select, zero = blanking
//   bcd_out      out 4*NUM_DIGITS    last completed frame, digit i at [4i+3:4i]
//   frame_valid  out 1               pulse, bcd_out updated on the same edge
//   err          out 1               pulse on a rejected dwell
//   err_sticky   out 1               latched err, cleared only by clr
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [0:6]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    frame_valid,
  output logic                    err,
  output logic                    err_sticky
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [0:6]              s_seg_q, s_seg_d;
  logic [NUM_DIGITS-1:0]   s_sel_q, s_sel_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] bcd_out_q, bcd_out_d;
  logic                    frame_valid_q, frame_valid_d;
  logic                    err_q, err_d;
  logic                    err_sticky_q, err_sticky_d;

  logic                    dec_valid;
  logic [3:0]              dec_value;
  logic                    changed;
  logic                    capture;
  logic                    sel_onehot;
  logic                    good_cap;
  logic                    bad_cap;
  logic                    complete;

  seg7_to_bcd u_dec (
    .seg   (s_seg_q),
    .valid (dec_valid),
    .value (dec_value)
  );

  always_comb begin
    s_seg_d       = seg_in;
    s_sel_d       = dig_sel;
    cnt_d         = cnt_q;
    done_d        = done_q;
    mask_d        = mask_q;
    shadow_d      = shadow_q;
    bcd_out_d     = bcd_out_q;
    frame_valid_d = 1'b0;
    err_d         = 1'b0;
    err_sticky_d  = err_sticky_q;

    changed    = ({seg_in, dig_sel} != {s_seg_q, s_sel_q});
    capture    = (cnt_q == CNT_MAX) && !done_q && (s_sel_q != '0);
    // x & (x-1) clears the lowest set bit, so zero means at most one bit set.
    sel_onehot = ((s_sel_q & (s_sel_q - 1'b1)) == '0);
    good_cap   = capture && dec_valid && sel_onehot;
    bad_cap    = capture && !good_cap;
    complete   = &mask_q;

    // A new sample starts a new dwell; this wins over a capture on the same
    // edge because the captured dwell is finished either way.
    if (changed) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      done_d = done_q | capture;
    end

    // The outgoing frame takes the shadow as it stood before this edge; any
    // capture on the same edge lands in the cleared mask for the next frame.
    if (complete) begin
      bcd_out_d     = shadow_q;
      frame_valid_d = 1'b1;
      mask_d        = '0;
    end

    if (good_cap) begin
      mask_d = mask_d | s_sel_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (s_sel_q[i]) shadow_d[4*i +: 4] = dec_value;
      end
    end

    if (bad_cap) begin
      err_d        = 1'b1;
      err_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      s_seg_q       <= '0;
      s_sel_q       <= '0;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      mask_q        <= '0;
      shadow_q      <= '0;
      bcd_out_q     <= '0;
      frame_valid_q <= 1'b0;
      err_q         <= 1'b0;
      err_sticky_q  <= 1'b0;
    end else begin
      s_seg_q       <= s_seg_d;
      s_sel_q       <= s_sel_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      mask_q        <= mask_d;
      shadow_q      <= shadow_d;
      bcd_out_q     <= bcd_out_d;
      frame_valid_q <= frame_valid_d;
      err_q         <= err_d;
      err_sticky_q  <= err_sticky_d;
    end
  end

  assign bcd_out     = bcd_out_q;
  assign frame_valid = frame_valid_q;
  assign err         = err_q;
  assign err_sticky  = err_sticky_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder
// Self-checking bench for seg7_scan_decoder. Stimulus is expressed as dwells
// (pattern, select, length); a dwell-level reference model predicts on which
// edge each capture, error pulse and frame completion must appear.
module tb_seg7_scan_decoder;

  localparam int NUM_DIGITS    = 4;
  localparam int STABLE_CYCLES = 4;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [0:6]  seg_in = '0;
  logic [3:0]  dig_sel = '0;
  logic [15:0] bcd_out;
  logic        frame_valid;
  logic        err;
  logic        err_sticky;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [0:6] digit_pat [10];
  logic [0:6] last_seg = '0;
  logic [3:0] last_sel = '0;

  typedef struct {
    int         edge_n;
    logic [0:6] seg;
    logic [3:0] sel;
  } cap_t;
  cap_t pend_q[$];

  int          obs_fv_cyc[$];
  logic [15:0] obs_fv_val[$];
  int          exp_fv_cyc[$];
  logic [15:0] exp_fv_val[$];
  int          obs_err_cyc[$];
  int          exp_err_cyc[$];

  logic [3:0]  m_mask   = '0;
  logic [15:0] m_shadow = '0;
  logic [15:0] m_bcd    = '0;
  logic        m_sticky = 1'b0;

  seg7_scan_decoder #(
    .NUM_DIGITS    (NUM_DIGITS),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .bcd_out     (bcd_out),
    .frame_valid (frame_valid),
    .err         (err),
    .err_sticky  (err_sticky)
  );

  always #5 clk = ~clk;

  // Returns {ok, value}: a digit glyph, a dark digit (blank code F), or not ok.
  function automatic logic [4:0] model_decode(input logic [0:6] p);
    logic [4:0] r;
    r = 5'b0;
    if (p == 7'b0000000) r = {1'b1, 4'hF};
    for (int d = 0; d < 10; d++) begin
      if (p == digit_pat[d]) r = {1'b1, 4'(d)};
    end
    return r;
  endfunction

  // Reference behaviour at one clock edge, in terms of scheduled captures.
  task automatic model_edge();
    cap_t       c;
    logic [4:0] dv;
    if (!clr) begin
      m_mask   = '0;
      m_shadow = '0;
      m_bcd    = '0;
      m_sticky = 1'b0;
      pend_q.delete();
    end else begin
      if (m_mask == 4'hF) begin
        exp_fv_cyc.push_back(cyc);
        exp_fv_val.push_back(m_shadow);
        m_bcd  = m_shadow;
        m_mask = '0;
      end
      if (pend_q.size() > 0 && pend_q[0].edge_n == cyc) begin
        c  = pend_q.pop_front();
        dv = model_decode(c.seg);
        if (dv[4] && $countones(c.sel) == 1) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (c.sel[i]) m_shadow[4*i +: 4] = dv[3:0];
          end
          m_mask = m_mask | c.sel;
        end else begin
          exp_err_cyc.push_back(cyc);
          m_sticky = 1'b1;
        end
      end
    end
  endtask

  // Drives one bus value for one edge and records what the DUT shows after it.
  task automatic step(input logic [0:6] seg, input logic [3:0] sel);
    seg_in  = seg;
    dig_sel = sel;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    if (frame_valid === 1'b1) begin
      obs_fv_cyc.push_back(cyc);
      obs_fv_val.push_back(bcd_out);
    end
    if (err === 1'b1) obs_err_cyc.push_back(cyc);
  endtask

  // A dwell is sampled first at the next edge; if long enough and selecting
  // something it is captured STABLE_CYCLES edges after that.
  task automatic run_dwell(input logic [0:6] seg, input logic [3:0] sel, input int len);
    cap_t c;
    c.edge_n = cyc + 1 + STABLE_CYCLES;
    c.seg    = seg;
    c.sel    = sel;
    if (sel != 4'b0 && len >= STABLE_CYCLES) pend_q.push_back(c);
    for (int k = 0; k < len; k++) step(seg, sel);
    last_seg = seg;
    last_sel = sel;
  endtask

  task automatic apply_reset(input int n);
    clr = 1'b0;
    for (int k = 0; k < n; k++) step(7'($urandom), 4'($urandom));
    clr      = 1'b1;
    last_seg = '0;
    last_sel = '0;
  endtask

  task automatic clear_trace();
    obs_fv_cyc.delete();
    obs_fv_val.delete();
    exp_fv_cyc.delete();
    exp_fv_val.delete();
    obs_err_cyc.delete();
    exp_err_cyc.delete();
  endtask

  task automatic test_reset();
    apply_reset(2);
    checks++;
    if (bcd_out !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_bcd: got %h expected 0000", bcd_out);
    end
    checks++;
    if (frame_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_frame_valid: got %b expected 0", frame_valid);
    end
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_err: got %b expected 0", err);
    end
    checks++;
    if (err_sticky !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_err_sticky: got %b expected 0", err_sticky);
    end
    clear_trace();
    run_dwell(7'b1011011, 4'b0001, 3);
    run_dwell(7'b0000000, 4'b0000, 2);
    run_dwell(7'b0110000, 4'b0010, 5);
    run_dwell(7'b1101101, 4'b0100, 5);
    run_dwell(7'b1111001, 4'b1000, 5);
    run_dwell(7'b0000000, 4'b0000, 3);
    checks++;
    if (obs_fv_cyc.size() != 0) begin
      failures++;
      $display("[TB] FAIL reset_short_dwell_frames: got %0d frames expected 0", obs_fv_cyc.size());
    end
    checks++;
    if (obs_err_cyc.size() != 0) begin
      failures++;
      $display("[TB] FAIL reset_short_dwell_err: got %0d errs expected 0", obs_err_cyc.size());
    end
  endtask

  task automatic test_full_frame();
    int t4;
    apply_reset(1);
    clear_trace();
    run_dwell(7'b1111001, 4'b0001, 5);
    run_dwell(7'b0110011, 4'b0010, 5);
    run_dwell(7'b1111110, 4'b0100, 5);
    t4 = cyc + 1;
    run_dwell(7'b1111011, 4'b1000, 5);
    run_dwell(7'b0000000, 4'b0000, 3);
    checks++;
    if (obs_fv_cyc.size() != 1) begin
      failures++;
      $display("[TB] FAIL full_frame_count: got %0d expected 1", obs_fv_cyc.size());
    end else begin
      checks++;
      if (obs_fv_val[0] !== 16'h9043) begin
        failures++;
        $display("[TB] FAIL full_frame_value: got %h expected 9043", obs_fv_val[0]);
      end
      checks++;
      if (obs_fv_cyc[0] != t4 + STABLE_CYCLES + 1) begin
        failures++;
        $display("[TB] FAIL full_frame_edge: got %0d expected %0d", obs_fv_cyc[0], t4 + STABLE_CYCLES + 1);
      end
    end
    checks++;
    if (bcd_out !== 16'h9043) begin
      failures++;
      $display("[TB] FAIL full_frame_hold: got %h expected 9043", bcd_out);
    end
    checks++;
    if (obs_err_cyc.size() != 0 || err_sticky !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_frame_err: got %0d errs sticky=%b expected 0 errs sticky=0", obs_err_cyc.size(), err_sticky);
    end
  endtask

  task automatic test_debounce();
    int t0;
    apply_reset(1);
    clear_trace();
    run_dwell(7'b1101101, 4'b0010, 5);
    run_dwell(7'b0110011, 4'b0100, 5);
    run_dwell(7'b1110000, 4'b1000, 5);
    run_dwell(7'b0110000, 4'b0001, 3);
    run_dwell(7'b0000000, 4'b0000, 1);
    run_dwell(7'b0000000, 4'b0000, 0);
    checks++;
    if (obs_fv_cyc.size() != 0) begin
      failures++;
      $display("[TB] FAIL debounce_short_ignored: got %0d frames expected 0", obs_fv_cyc.size());
    end
    t0 = cyc + 1;
    run_dwell(7'b0110000, 4'b0001, 4);
    run_dwell(7'b0000000, 4'b0000, 3);
    checks++;
    if (obs_fv_cyc.size() != 1) begin
      failures++;
      $display("[TB] FAIL debounce_frame_count: got %0d expected 1", obs_fv_cyc.size());
    end else begin
      checks++;
      if (obs_fv_cyc[0] != t0 + STABLE_CYCLES + 1) begin
        failures++;
        $display("[TB] FAIL debounce_capture_edge: got %0d expected %0d", obs_fv_cyc[0], t0 + STABLE_CYCLES + 1);
      end
      checks++;
      if (obs_fv_val[0] !== 16'h7421) begin
        failures++;
        $display("[TB] FAIL debounce_value: got %h expected 7421", obs_fv_val[0]);
      end
    end
  endtask

  task automatic test_error();
    int t;
    apply_reset(1);
    clear_trace();
    t = cyc + 1;
    run_dwell(7'b1010101, 4'b0010, 6);
    checks++;
    if (obs_err_cyc.size() != 1) begin
      failures++;
      $display("[TB] FAIL error_pulse_count: got %0d expected 1", obs_err_cyc.size());
    end else begin
      checks++;
      if (obs_err_cyc[0] != t + STABLE_CYCLES) begin
        failures++;
        $display("[TB] FAIL error_pulse_edge: got %0d expected %0d", obs_err_cyc[0], t + STABLE_CYCLES);
      end
    end
    checks++;
    if (err_sticky !== 1'b1) begin
      failures++;
      $display("[TB] FAIL error_sticky_set: got %b expected 1", err_sticky);
    end
    run_dwell(7'b1111111, 4'b0001, 5);
    run_dwell(7'b1011111, 4'b0100, 5);
    run_dwell(7'b1111110, 4'b1000, 5);
    run_dwell(7'b0000000, 4'b0000, 3);
    checks++;
    if (obs_fv_cyc.size() != 0) begin
      failures++;
      $display("[TB] FAIL error_mask_unchanged: got %0d frames expected 0", obs_fv_cyc.size());
    end
    run_dwell(7'b1011011, 4'b0110, 6);
    checks++;
    if (obs_err_cyc.size() != 2) begin
      failures++;
      $display("[TB] FAIL error_multihot: got %0d errs expected 2", obs_err_cyc.size());
    end
    run_dwell(7'b1011011, 4'b0010, 5);
    run_dwell(7'b0000000, 4'b0000, 3);
    checks++;
    if (obs_fv_cyc.size() != 1 || bcd_out !== 16'h0658) begin
      failures++;
      $display("[TB] FAIL error_then_frame: got %0d frames bcd %h expected 1 frames bcd 0658", obs_fv_cyc.size(), bcd_out);
    end
    checks++;
    if (err_sticky !== 1'b1) begin
      failures++;
      $display("[TB] FAIL error_sticky_hold: got %b expected 1", err_sticky);
    end
  endtask

  task automatic test_blank_gaps();
    int t;
    apply_reset(1);
    clear_trace();
    run_dwell(7'b1011011, 4'b0001, 5);
    run_dwell(7'b0000000, 4'b0000, 2);
    run_dwell(7'b1110000, 4'b0010, 5);
    run_dwell(7'b0000000, 4'b0000, 2);
    run_dwell(7'b1111111, 4'b0100, 5);
    run_dwell(7'b0000000, 4'b0000, 2);
    t = cyc + 1;
    run_dwell(7'b0000000, 4'b1000, 5);
    run_dwell(7'b0000000, 4'b0000, 3);
    checks++;
    if (obs_fv_cyc.size() != 1) begin
      failures++;
      $display("[TB] FAIL blank_frame_count: got %0d expected 1", obs_fv_cyc.size());
    end else begin
      checks++;
      if (obs_fv_val[0] !== 16'hF875 || obs_fv_cyc[0] != t + STABLE_CYCLES + 1) begin
        failures++;
        $display("[TB] FAIL blank_frame: got %h at %0d expected F875 at %0d", obs_fv_val[0], obs_fv_cyc[0], t + STABLE_CYCLES + 1);
      end
    end
    checks++;
    if (obs_err_cyc.size() != 0 || err_sticky !== 1'b0) begin
      failures++;
      $display("[TB] FAIL blank_no_err: got %0d errs sticky=%b expected 0 errs sticky=0", obs_err_cyc.size(), err_sticky);
    end
  endtask

  task automatic test_mid_reset();
    int t;
    apply_reset(1);
    run_dwell(7'b0110000, 4'b0001, 5);
    run_dwell(7'b1101101, 4'b0010, 5);
    apply_reset(1);
    clear_trace();
    run_dwell(7'b1011011, 4'b0100, 5);
    run_dwell(7'b1011111, 4'b1000, 5);
    run_dwell(7'b1110000, 4'b0001, 5);
    t = cyc + 1;
    run_dwell(7'b1111111, 4'b0010, 5);
    run_dwell(7'b0000000, 4'b0000, 3);
    checks++;
    if (obs_fv_cyc.size() != 1) begin
      failures++;
      $display("[TB] FAIL mid_reset_frame_count: got %0d expected 1", obs_fv_cyc.size());
    end else begin
      checks++;
      if (obs_fv_val[0] !== 16'h6587 || obs_fv_cyc[0] != t + STABLE_CYCLES + 1) begin
        failures++;
        $display("[TB] FAIL mid_reset_frame: got %h at %0d expected 6587 at %0d", obs_fv_val[0], obs_fv_cyc[0], t + STABLE_CYCLES + 1);
      end
    end
  endtask

  task automatic test_random();
    logic [0:6] seg;
    logic [3:0] sel;
    int         n;
    apply_reset(1);
    clear_trace();
    for (int k = 0; k < 80; k++) begin
      n = 0;
      do begin
        if ($urandom_range(0, 3) == 0) sel = 4'b0000;
        else if ($urandom_range(0, 6) == 0) sel = 4'($urandom_range(1, 15));
        else sel = 4'(1 << $urandom_range(0, 3));
        case ($urandom_range(0, 9))
          0:       seg = 7'b0000000;
          1, 2:    seg = 7'($urandom);
          default: seg = digit_pat[$urandom_range(0, 9)];
        endcase
        n++;
      end while (seg == last_seg && sel == last_sel && n < 10);
      if (seg == last_seg && sel == last_sel) sel = ~last_sel;
      run_dwell(seg, sel, int'($urandom_range(1, 7)));
    end
    run_dwell((last_sel == 4'b0) ? ~last_seg : 7'b0000000, 4'b0000, 3);
    checks++;
    if (obs_fv_cyc.size() != exp_fv_cyc.size()) begin
      failures++;
      $display("[TB] FAIL random_frame_count: got %0d expected %0d", obs_fv_cyc.size(), exp_fv_cyc.size());
    end else begin
      for (int i = 0; i < obs_fv_cyc.size(); i++) begin
        checks++;
        if (obs_fv_cyc[i] != exp_fv_cyc[i] || obs_fv_val[i] !== exp_fv_val[i]) begin
          failures++;
          $display("[TB] FAIL random_frame_%0d: got %h at %0d expected %h at %0d", i, obs_fv_val[i], obs_fv_cyc[i], exp_fv_val[i], exp_fv_cyc[i]);
        end
      end
    end
    checks++;
    if (obs_err_cyc.size() != exp_err_cyc.size()) begin
      failures++;
      $display("[TB] FAIL random_err_count: got %0d expected %0d", obs_err_cyc.size(), exp_err_cyc.size());
    end else begin
      for (int i = 0; i < obs_err_cyc.size(); i++) begin
        checks++;
        if (obs_err_cyc[i] != exp_err_cyc[i]) begin
          failures++;
          $display("[TB] FAIL random_err_%0d: got edge %0d expected edge %0d", i, obs_err_cyc[i], exp_err_cyc[i]);
        end
      end
    end
    checks++;
    if (bcd_out !== m_bcd || err_sticky !== m_sticky) begin
      failures++;
      $display("[TB] FAIL random_final: got bcd %h sticky %b expected bcd %h sticky %b", bcd_out, err_sticky, m_bcd, m_sticky);
    end
  endtask

  initial begin
    digit_pat = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                  7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    $display("[TB] start");
    test_reset();
    test_full_frame();
    test_debounce();
    test_error();
    test_blank_gaps();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
Receive-side counterpart of the BCD-to-7-segment display driver. Monitors a multiplexed 7-segment bus (segment lines plus one-hot digit select) and debounces each digit dwell. Decodes each stable segment pattern back to BCD and assembles a complete multi-digit frame. Used for display loopback checking and for reading panel values back into the datapath.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (width of dig_sel, number of BCD nibbles)
STABLE_CYCLES, 4, consecutive identical samples required before a dwell is accepted (minimum 2)

Ports:
clk  input  1  system clock, all logic on rising edge
clr  input  1  reset, synchronous, active-low
seg_in  input  [0:6]  segment lines, bit 0 = a ... bit 6 = g, 1 = segment lit
dig_sel  input  NUM_DIGITS  digit select, one-hot, bit i = digit i, all-zero = blanking interval
bcd_out  output  4*NUM_DIGITS  last completed frame, digit i at [4i+3:4i]
frame_valid  output  1  one-cycle pulse; bcd_out updated on the same edge
err  output  1  one-cycle pulse on a rejected dwell
err_sticky  output  1  set with err, cleared only by clr

Behaviour:
- Reset (clr=0 at a rising edge): bcd_out=0, frame_valid=0, err=0, err_sticky=0. Internal state also clears: sample registers, stability counter, dwell-done flag, captured mask, shadow frame. Reset mid-dwell or mid-frame discards all partial data.
- Sample stage: seg_in and dig_sel are registered every edge (s_seg, s_sel). Reset value of s_sel is 0.
- Stability counter cnt, width clog2(STABLE_CYCLES):
  - {s_seg,s_sel} differs from the previous sample -> cnt=0, done=0.
  - Otherwise cnt increments, saturating at STABLE_CYCLES-1.
- Capture condition: cnt==STABLE_CYCLES-1, done=0, s_sel!=0. On that edge, done is set, giving exactly one capture per dwell.
- Timing: an input held from before edge 1 is sampled at edge 1 and captured at edge STABLE_CYCLES+1. A dwell shorter than STABLE_CYCLES sampled edges is ignored.
- Decode at capture:
  - 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9.
  - 0000000 = blank, stored as 4'hF and treated as valid.
  - Any other pattern is invalid.
- Valid capture with one-hot s_sel: shadow nibble i is written and mask bit i is set. A repeated capture of the same digit before the frame completes overwrites the nibble.
- Invalid pattern, or multi-hot s_sel, at capture: err=1 for one cycle, err_sticky=1, no write, mask unchanged.
- s_sel all-zero: no capture, no error. This is a blanking gap and resets stability as a change.
- Frame completion: when the mask becomes all ones, on the next edge bcd_out<=shadow, frame_valid=1 and mask<=0. This is one cycle after the capture that completed it.
- Capture coinciding with the frame-completion edge: the capture is applied to the shadow and to the freshly cleared mask, so it counts toward the next frame. The outgoing frame uses the pre-capture shadow.
- frame_valid and err are high for exactly one cycle per event, never back-to-back from a single dwell.

Decomposition:
- Package seg7_pkg:
  - segment pattern constants SEG_0..SEG_9 and SEG_BLANK
  - BLANK_CODE = 4'hF
  - bit-order note (index 0 = segment a), shared with the display driver
- Sub-module seg7_to_bcd: combinational pattern -> {valid, value[3:0]}, instantiated once on s_seg.
- The top level holds the sampler, stability counter, capture/mask logic and the output register.

Test Plan:
- Reset: clr=0 for 2 cycles with random bus activity -> bcd_out=0, frame_valid=0, err_sticky=0. After clr=1, a 3-cycle dwell causes no capture.
- Full frame: dwell 5 cycles each on dig_sel=0001/0010/0100/1000 with 1111001, 0110011, 1111110, 1111011 -> single frame_valid pulse, bcd_out=16'h9043.
- Debounce: digit 0 held 3 cycles, then 4 cycles (STABLE_CYCLES=4) -> capture only on the 4-cycle dwell, exactly at edge 5 of that dwell.
- Glitch/error: dig_sel=0010 with 1010101 for 6 cycles -> err pulse once, err_sticky=1, mask bit 1 stays 0. dig_sel=0110 held -> err again.
- Blank and gaps: 0000000 on digit 3 with all-zero dig_sel gaps between dwells -> frame completes with nibble 3 = F, no err.
- Mid-frame reset: 2 digits captured, clr=0 one cycle, then 4 new digits -> frame_valid only after all 4 new digits, with values from the new dwells only.
